// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI controller blocks.
// FSM encodings, op-type codes and default sizes.
package spi_ctrl_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_t;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/spi_bus_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request
// searching upward from the slot after the last grant.
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic [IW-1:0] o_pick,
    output logic          o_any
);

    localparam logic [IW:0] LP_N = (IW+1)'(N);

    logic [IW:0] w_idx;
    logic        w_found;

    always_comb begin
        o_pick  = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 1; k <= N; k++) begin
            // last+k never exceeds 2N-1, so one wrap suffices
            w_idx = {1'b0, i_last} + (IW+1)'(k);
            if (w_idx >= LP_N) begin
                w_idx = w_idx - LP_N;
            end
            if (!w_found && i_req[w_idx[IW-1:0]]) begin
                w_found = 1'b1;
                o_pick  = w_idx[IW-1:0];
            end
        end
        o_any = |i_req;
    end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing the SPI bridge bus port between
// NUM_REQ requesters, with one pending op per requester and timeout.
module spi_bus_arbiter
    import spi_ctrl_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_read,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_write_data,
    output logic [DATA_WIDTH-1:0]         req_read_data,
    output logic [NUM_REQ-1:0]            req_read_response,
    output logic [NUM_REQ-1:0]            req_write_response,
    output logic [NUM_REQ-1:0]            req_error,
    output logic                          bus_read,
    output logic                          bus_write,
    output logic [DATA_WIDTH-1:0]         bus_write_data,
    input  logic                          bus_read_response,
    input  logic                          bus_write_response,
    input  logic [DATA_WIDTH-1:0]         bus_read_data,
    output logic [IW-1:0]                 grant_id,
    output logic                          busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    arb_state_t              r_state;
    logic [TW-1:0]           r_timer;
    logic [IW-1:0]           r_grant;
    logic [IW-1:0]           r_last;
    logic                    r_op;
    logic [NUM_REQ-1:0]      r_pend_v;
    logic [NUM_REQ-1:0]      r_pend_wr;
    logic [DATA_WIDTH-1:0]   r_pend_data [NUM_REQ];
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic [DATA_WIDTH-1:0]   r_bus_wdata;
    logic                    r_bus_read;
    logic                    r_bus_write;
    logic [NUM_REQ-1:0]      r_rd_resp;
    logic [NUM_REQ-1:0]      r_wr_resp;
    logic [NUM_REQ-1:0]      r_err;

    logic [IW-1:0]           w_pick;
    logic                    w_any;
    logic                    w_done;
    logic                    w_tmo;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .i_req  (r_pend_v),
        .i_last (r_last),
        .o_pick (w_pick),
        .o_any  (w_any)
    );

    // only the response matching the issued op type counts
    assign w_done = (r_op == OP_WRITE) ? bus_write_response
                                       : bus_read_response;
    assign w_tmo  = &r_timer;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ARB_IDLE;
            r_timer     <= '0;
            r_grant     <= '0;
            r_last      <= IW'(NUM_REQ - 1);
            r_op        <= OP_READ;
            r_pend_v    <= '0;
            r_pend_wr   <= '0;
            r_rdata     <= '0;
            r_bus_wdata <= '0;
            r_bus_read  <= 1'b0;
            r_bus_write <= 1'b0;
            r_rd_resp   <= '0;
            r_wr_resp   <= '0;
            r_err       <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                r_pend_data[i] <= '0;
            end
        end else begin
            r_bus_read  <= 1'b0;
            r_bus_write <= 1'b0;
            r_rd_resp   <= '0;
            r_wr_resp   <= '0;
            r_err       <= '0;

            unique case (r_state)
                ARB_IDLE: begin
                    if (w_any) begin
                        r_grant     <= w_pick;
                        r_state     <= ARB_WAIT;
                        r_timer     <= '0;
                        r_op        <= r_pend_wr[w_pick];
                        r_bus_wdata <= r_pend_data[w_pick];
                        r_bus_write <= r_pend_wr[w_pick];
                        r_bus_read  <= !r_pend_wr[w_pick];
                    end
                end
                ARB_WAIT: begin
                    if (w_done || w_tmo) begin
                        if (r_op == OP_WRITE) begin
                            r_wr_resp[r_grant] <= 1'b1;
                        end else begin
                            r_rd_resp[r_grant] <= 1'b1;
                            r_rdata <= w_done ? bus_read_data : '0;
                        end
                        r_err[r_grant]    <= !w_done;
                        r_pend_v[r_grant] <= 1'b0;
                        r_last            <= r_grant;
                        r_state           <= ARB_IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
            endcase

            // a full slot drops new pulses, even on its completion edge
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!r_pend_v[i] && (req_write[i] || req_read[i])) begin
                    r_pend_v[i]    <= 1'b1;
                    r_pend_wr[i]   <= req_write[i];
                    r_pend_data[i] <= req_write[i]
                        ? req_write_data[i*DATA_WIDTH +: DATA_WIDTH]
                        : '0;
                end
            end
        end
    end

    assign req_read_data      = r_rdata;
    assign req_read_response  = r_rd_resp;
    assign req_write_response = r_wr_resp;
    assign req_error          = r_err;
    assign bus_read           = r_bus_read;
    assign bus_write          = r_bus_write;
    assign bus_write_data     = r_bus_wdata;
    assign grant_id           = r_grant;
    assign busy               = (r_state == ARB_WAIT);

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter: two requesters, short timeout.
// Inputs change and outputs are sampled on the falling edge.
module tb_spi_bus_arbiter;

    localparam int NR = 2;
    localparam int DW = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [NR-1:0]    req_read;
    logic [NR-1:0]    req_write;
    logic [NR*DW-1:0] req_write_data;
    logic [DW-1:0]    req_read_data;
    logic [NR-1:0]    req_read_response;
    logic [NR-1:0]    req_write_response;
    logic [NR-1:0]    req_error;
    logic             bus_read;
    logic             bus_write;
    logic [DW-1:0]    bus_write_data;
    logic             bus_read_response;
    logic             bus_write_response;
    logic [DW-1:0]    bus_read_data;
    logic [0:0]       grant_id;
    logic             busy;

    int checks = 0;
    int errors = 0;

    spi_bus_arbiter #(
        .NUM_REQ        (NR),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .req_read           (req_read),
        .req_write          (req_write),
        .req_write_data     (req_write_data),
        .req_read_data      (req_read_data),
        .req_read_response  (req_read_response),
        .req_write_response (req_write_response),
        .req_error          (req_error),
        .bus_read           (bus_read),
        .bus_write          (bus_write),
        .bus_write_data     (bus_write_data),
        .bus_read_response  (bus_read_response),
        .bus_write_response (bus_write_response),
        .bus_read_data      (bus_read_data),
        .grant_id           (grant_id),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic quiet();
        req_read           = '0;
        req_write          = '0;
        bus_read_response  = 1'b0;
        bus_write_response = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        req_write_data = '0;
        bus_read_data  = '0;
        quiet();
        repeat (3) tick();
        reset = 1'b0;
        tick();

        chk("rst_busy", busy, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_bus", {bus_read, bus_write}, 0);
        chk("rst_wdata", bus_write_data, 0);
        chk("rst_resp", {req_read_response, req_write_response,
                         req_error}, 0);
        chk("rst_rdata", req_read_data, 0);

        // single write from requester 0
        req_write = 2'b01;
        req_write_data[31:0] = 32'hDEADBEEF;
        tick();
        quiet();
        chk("w1_not_yet", bus_write, 0);
        tick();
        chk("w1_issue", {bus_write, bus_read}, 2'b10);
        chk("w1_wdata", bus_write_data, 32'hDEADBEEF);
        chk("w1_busy", busy, 1);
        chk("w1_grant", grant_id, 0);
        tick();
        chk("w1_pulse1", bus_write, 0);
        chk("w1_hold", bus_write_data, 32'hDEADBEEF);
        tick();
        bus_write_response = 1'b1;
        tick();
        quiet();
        chk("w1_resp", req_write_response, 2'b01);
        chk("w1_err", req_error, 0);
        chk("w1_idle", busy, 0);
        tick();
        chk("w1_resp_pulse", req_write_response, 0);

        // single read from requester 1
        req_read = 2'b10;
        tick();
        quiet();
        tick();
        chk("r1_issue", {bus_write, bus_read}, 2'b01);
        chk("r1_grant", grant_id, 1);
        bus_read_data     = 32'h12345678;
        bus_read_response = 1'b1;
        tick();
        quiet();
        chk("r1_resp", req_read_response, 2'b10);
        chk("r1_data", req_read_data, 32'h12345678);
        chk("r1_err", req_error, 0);
        tick();

        // contention: write0 and read1 together
        req_write = 2'b01;
        req_read  = 2'b10;
        req_write_data[31:0] = 32'hAAAA5555;
        tick();
        quiet();
        tick();
        chk("c1_first", {grant_id, bus_write}, 2'b01);
        chk("c1_wdata", bus_write_data, 32'hAAAA5555);
        tick();
        bus_write_response = 1'b1;
        tick();
        quiet();
        chk("c1_resp0", req_write_response, 2'b01);
        chk("c1_gap", {bus_read, bus_write}, 0);
        tick();
        chk("c1_second", {grant_id, bus_read}, 2'b11);
        bus_write_response = 1'b1;
        tick();
        quiet();
        chk("c1_mismatch", {busy, req_read_response,
                            req_write_response}, 5'b10000);
        bus_read_data     = 32'hCAFEF00D;
        bus_read_response = 1'b1;
        tick();
        quiet();
        chk("c1_resp1", req_read_response, 2'b10);
        chk("c1_data1", req_read_data, 32'hCAFEF00D);

        // second round rotates from last grant 1 back to 0
        req_write = 2'b01;
        req_read  = 2'b10;
        tick();
        quiet();
        tick();
        chk("c2_first", {grant_id, bus_write}, 2'b01);
        bus_write_response = 1'b1;
        tick();
        quiet();
        chk("c2_resp0", req_write_response, 2'b01);
        tick();
        chk("c2_second", {grant_id, bus_read}, 2'b11);
        bus_read_response = 1'b1;
        tick();
        quiet();
        chk("c2_resp1", req_read_response, 2'b10);
        chk("c2_hold", req_read_data, 32'hCAFEF00D);

        // drop rule: pulses while slot 0 is pending
        req_read = 2'b01;
        tick();
        quiet();
        tick();
        chk("d1_issue", {grant_id, bus_read}, 2'b01);
        req_read = 2'b01;
        tick();
        quiet();
        bus_read_data     = 32'h11112222;
        bus_read_response = 1'b1;
        req_read          = 2'b01;
        tick();
        quiet();
        chk("d1_resp", req_read_response, 2'b01);
        chk("d1_data", req_read_data, 32'h11112222);
        tick();
        chk("d1_no_reissue", {busy, bus_read}, 0);
        tick();
        chk("d1_still_idle", {busy, bus_read}, 0);

        // read and write together: only the write is kept
        req_read  = 2'b01;
        req_write = 2'b01;
        req_write_data[31:0] = 32'h0BADF00D;
        tick();
        quiet();
        tick();
        chk("d2_issue", {bus_write, bus_read}, 2'b10);
        chk("d2_wdata", bus_write_data, 32'h0BADF00D);
        bus_write_response = 1'b1;
        tick();
        quiet();
        chk("d2_resp", {req_write_response, req_read_response}, 4'b0100);
        tick();
        chk("d2_no_read", {busy, bus_read}, 0);

        // timeout on a silent bridge
        req_read = 2'b01;
        tick();
        quiet();
        tick();
        chk("t_issue", {busy, bus_read}, 2'b11);
        repeat (15) tick();
        chk("t_wait", {busy, req_read_response, req_error}, 5'b10000);
        tick();
        chk("t_resp", req_read_response, 2'b01);
        chk("t_err", req_error, 2'b01);
        chk("t_data", req_read_data, 0);
        chk("t_idle", busy, 0);
        tick();
        chk("t_err_pulse", req_error, 0);

        // reset in the middle of a wait
        req_write = 2'b10;
        req_write_data[63:32] = 32'h00000005;
        tick();
        quiet();
        tick();
        chk("x_issue", {grant_id, bus_write}, 2'b11);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus_write_response = 1'b1;
        tick();
        quiet();
        chk("x_no_resp", {req_write_response, req_read_response,
                          req_error}, 0);
        chk("x_busy", busy, 0);
        chk("x_grant", grant_id, 0);
        tick();
        chk("x_cleared", {busy, bus_read, bus_write}, 0);

        // after reset requester 0 wins first
        req_read = 2'b11;
        tick();
        quiet();
        tick();
        chk("x_first", {grant_id, bus_read}, 2'b01);
        bus_read_response = 1'b1;
        tick();
        quiet();
        chk("x_resp0", req_read_response, 2'b01);
        tick();
        chk("x_next", {grant_id, bus_read}, 2'b11);
        bus_read_response = 1'b1;
        tick();
        quiet();
        chk("x_resp1", req_read_response, 2'b10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
